// File: rtl/palette_mapper.sv
// palette_mapper
//   Maps a (mode, colour index) pair to RGB through a run-time-writable
//   palette, with a fixed 2-clock pipeline and a retriggerable flash effect
//   (channel inversion) used for note-hit feedback.
//
//   Optional build macro: PALETTE_DIM_EN adds a per-pixel 'dim' input that
//   halves each channel (logical right shift by 1) after flash inversion.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_en/wr_mode/wr_idx     palette write strobe and entry address
//   wr_rgb                   {R,G,B} write data
//   pix_valid/color_mode/color  lookup request
//   dim (PALETTE_DIM_EN)     halve the requested pixel
//   flash_trig               start or retrigger the flash window
//   red/green/blue           RGB output, held while out_valid is low
//   out_valid                RGB valid, two clocks after pix_valid
//   flash_active             flash counter is nonzero
module palette_mapper #(
  parameter int CHANNEL_W    = 4,
  parameter int MODE_W       = 1,
  parameter int IDX_W        = 3,
  parameter int FLASH_CYCLES = 16,
  parameter int FLASH_CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [MODE_W-1:0]      wr_mode,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [3*CHANNEL_W-1:0] wr_rgb,
  input  logic                   pix_valid,
  input  logic [MODE_W-1:0]      color_mode,
  input  logic [IDX_W-1:0]       color,
`ifdef PALETTE_DIM_EN
  input  logic                   dim,
`endif
  input  logic                   flash_trig,
  output logic [CHANNEL_W-1:0]   red,
  output logic [CHANNEL_W-1:0]   green,
  output logic [CHANNEL_W-1:0]   blue,
  output logic                   out_valid,
  output logic                   flash_active
);

  localparam int NUM_MODES = 2**MODE_W;
  localparam int NUM_IDX   = 2**IDX_W;
  localparam int DEPTH     = NUM_MODES * NUM_IDX;
  localparam int ADDR_W    = MODE_W + IDX_W;
  localparam int RGB_W     = 3 * CHANNEL_W;

  // Reset palette contents in 12-bit nibble form {R,G,B}.
  function automatic logic [11:0] default_nib(input int mode, input int idx);
    logic [11:0] n;
    n = 12'h000;
    if (mode == 0) begin
      case (idx)
        0:       n = 12'h000;
        1:       n = 12'hFFF;
        2:       n = 12'h888;
        3:       n = 12'h421;
        default: n = 12'hFFF;
      endcase
    end else if (mode == 1) begin
      case (idx)
        0:       n = 12'h0F0;
        1:       n = 12'hF00;
        2:       n = 12'hFF0;
        3:       n = 12'h00F;
        default: n = 12'hFA0;
      endcase
    end
    return n;
  endfunction

  // Spread a nibble over CHANNEL_W bits MSB-first, repeating the nibble
  // into wider channels and dropping low bits for narrower ones.
  function automatic logic [CHANNEL_W-1:0] scale_nib(input logic [3:0] nib);
    logic [CHANNEL_W-1:0] s;
    for (int b = 0; b < CHANNEL_W; b++) begin
      s[CHANNEL_W-1-b] = nib[3-(b%4)];
    end
    return s;
  endfunction

  function automatic logic [RGB_W-1:0] default_rgb(input int mode, input int idx);
    logic [11:0] n;
    n = default_nib(mode, idx);
    return {scale_nib(n[11:8]), scale_nib(n[7:4]), scale_nib(n[3:0])};
  endfunction

  logic [DEPTH-1:0][RGB_W-1:0] pal_q;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W-1:0]           rd_addr;

  assign wr_addr = {wr_mode, wr_idx};
  assign rd_addr = {color_mode, color};

  // Palette register file; reset restores the defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pal_q[i] <= default_rgb(i / NUM_IDX, i % NUM_IDX);
      end
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_W'(i)) pal_q[i] <= wr_rgb;
      end
    end
  end

  // Stage 1: the read uses pal_q before this edge's write lands, so a
  // same-cycle write/lookup of one entry returns the old value.
  logic             s1_valid_q;
  logic [RGB_W-1:0] s1_rgb_q;
`ifdef PALETTE_DIM_EN
  logic             s1_dim_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
`ifdef PALETTE_DIM_EN
      s1_dim_q   <= 1'b0;
`endif
    end else begin
      s1_valid_q <= pix_valid;
      s1_rgb_q   <= pal_q[rd_addr];
`ifdef PALETTE_DIM_EN
      s1_dim_q   <= dim;
`endif
    end
  end

  // Flash counter: trigger reloads (no accumulation), else count down to 0.
  logic [FLASH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   flash_q;

  always_comb begin
    cnt_d = cnt_q;
    if (flash_trig)        cnt_d = FLASH_CNT_W'(FLASH_CYCLES);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // flash_q tracks cnt_q != 0 exactly, but as its own flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      flash_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= (cnt_d != '0);
    end
  end

  // Stage 2: flash inversion, then optional dim; hold RGB on invalid slots.
  logic [RGB_W-1:0] rgb_q, rgb_d, px;
  logic             out_valid_q;

  always_comb begin
    px = flash_q ? ~s1_rgb_q : s1_rgb_q;
`ifdef PALETTE_DIM_EN
    if (s1_dim_q) begin
      for (int c = 0; c < 3; c++) begin
        px[c*CHANNEL_W +: CHANNEL_W] = px[c*CHANNEL_W +: CHANNEL_W] >> 1;
      end
    end
`endif
    rgb_d = s1_valid_q ? px : rgb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      out_valid_q <= s1_valid_q;
    end
  end

  assign red          = rgb_q[RGB_W-1 -: CHANNEL_W];
  assign green        = rgb_q[2*CHANNEL_W-1 -: CHANNEL_W];
  assign blue         = rgb_q[CHANNEL_W-1:0];
  assign out_valid    = out_valid_q;
  assign flash_active = flash_q;

endmodule
